// File: rtl/int_issue_queue_pkg.sv
// Shared uop/wakeup types for the integer issue queue. The opcode and immediate
// enums live in their own small packages so decode stages can import them alone.
package uopc;
   typedef enum logic [3:0] {
      UOP_NOP, UOP_ADD, UOP_ADDI, UOP_SUB, UOP_AND, UOP_OR, UOP_XOR, UOP_SLT,
      UOP_LUI, UOP_BEQ, UOP_BNE, UOP_BLT, UOP_JAL, UOP_JALR
   } micro_opcode_t;
endpackage

package immt;
   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_type_t;
endpackage

package int_issue_queue_pkg;
   localparam int IQ_DEPTH = 8;
   localparam int IQ_NWAKE = 2;
   localparam int PREG_W   = 6;
   localparam int ROB_W    = 5;

   typedef struct packed {
      uopc::micro_opcode_t uopcode;
      logic [19:0]         packed_imm;
      immt::imm_type_t     imm_type;
      logic [PREG_W-1:0]   prs1;
      logic [PREG_W-1:0]   prs2;
      logic [PREG_W-1:0]   pdst;
      logic [ROB_W-1:0]    rob_idx;
      logic                uses_rs1;
      logic                uses_rs2;
   } iq_uop_t;

   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] pdst;
   } wake_t;
endpackage

// File: rtl/iq_entry_wake.sv
// Busy-bit update for one uop against every wakeup port. Unused sources and
// the hardwired zero register are never reported busy.
module iq_entry_wake
   import int_issue_queue_pkg::*;
#(
   parameter int NWAKE = IQ_NWAKE
) (
   input  logic              i_b1,
   input  logic              i_b2,
   input  logic              i_use1,
   input  logic              i_use2,
   input  logic [PREG_W-1:0] i_prs1,
   input  logic [PREG_W-1:0] i_prs2,
   input  wake_t             i_wake [NWAKE],
   output logic              o_b1,
   output logic              o_b2
);
   logic w_hit1;
   logic w_hit2;

   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      for (int k = 0; k < NWAKE; k++) begin
         if (i_wake[k].valid && (i_wake[k].pdst == i_prs1)) w_hit1 = 1'b1;
         if (i_wake[k].valid && (i_wake[k].pdst == i_prs2)) w_hit2 = 1'b1;
      end
   end

   assign o_b1 = i_b1 && i_use1 && (i_prs1 != '0) && !w_hit1;
   assign o_b2 = i_b2 && i_use2 && (i_prs2 != '0) && !w_hit2;
endmodule

// File: rtl/int_issue_queue.sv
// Collapsing, age-ordered integer issue queue: entry 0 is oldest, the oldest
// entry with both sources ready is offered to register-read each cycle.
module int_issue_queue
   import int_issue_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int NWAKE = IQ_NWAKE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       dis_valid,
   output logic                       dis_ready,
   input  iq_uop_t                    dis_uop,
   input  logic                       dis_prs1_busy,
   input  logic                       dis_prs2_busy,
   input  logic [NWAKE-1:0]           wake_valid,
   input  logic [NWAKE*PREG_W-1:0]    wake_pdst,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output iq_uop_t                    iss_uop,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_b1;
   logic [DEPTH-1:0] r_b2;
   iq_uop_t          r_uop [DEPTH];
   logic [CW-1:0]    r_count;

   wake_t            w_wake [NWAKE];
   logic [DEPTH-1:0] w_b1_upd;
   logic [DEPTH-1:0] w_b2_upd;
   logic             w_dis_b1;
   logic             w_dis_b2;
   logic [DEPTH-1:0] w_ready;
   logic [IW-1:0]    w_sel;
   logic             w_any;
   logic             w_fire;
   logic             w_dis_fire;
   logic [CW-1:0]    w_wpos;
   int               w_src;
   logic [DEPTH-1:0] w_nvalid;
   logic [DEPTH-1:0] w_nb1;
   logic [DEPTH-1:0] w_nb2;
   iq_uop_t          w_nuop [DEPTH];
   logic [CW-1:0]    w_ncount;

   always_comb begin
      for (int k = 0; k < NWAKE; k++) begin
         w_wake[k].valid = wake_valid[k];
         w_wake[k].pdst  = wake_pdst[k*PREG_W +: PREG_W];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_wake
      iq_entry_wake #(.NWAKE(NWAKE)) u_wake (
         .i_b1   (r_b1[i]),
         .i_b2   (r_b2[i]),
         .i_use1 (r_uop[i].uses_rs1),
         .i_use2 (r_uop[i].uses_rs2),
         .i_prs1 (r_uop[i].prs1),
         .i_prs2 (r_uop[i].prs2),
         .i_wake (w_wake),
         .o_b1   (w_b1_upd[i]),
         .o_b2   (w_b2_upd[i])
      );
   end

   // Incoming uop sees the same wakeups so a same-cycle broadcast is not lost.
   iq_entry_wake #(.NWAKE(NWAKE)) u_dis_wake (
      .i_b1   (dis_prs1_busy),
      .i_b2   (dis_prs2_busy),
      .i_use1 (dis_uop.uses_rs1),
      .i_use2 (dis_uop.uses_rs2),
      .i_prs1 (dis_uop.prs1),
      .i_prs2 (dis_uop.prs2),
      .i_wake (w_wake),
      .o_b1   (w_dis_b1),
      .o_b2   (w_dis_b2)
   );

   // Select looks only at registered busy bits: a wakeup helps one cycle later.
   assign w_ready = r_valid & ~r_b1 & ~r_b2;

   always_comb begin
      w_sel = '0;
      w_any = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_ready[i] && !w_any) begin
            w_sel = IW'(i);
            w_any = 1'b1;
         end
      end
   end

   assign dis_ready  = (r_count < CW'(DEPTH));
   assign iss_valid  = w_any && !flush;
   assign iss_uop    = iss_valid ? r_uop[w_sel] : '0;
   assign count      = r_count;
   assign w_fire     = iss_valid && iss_ready;
   assign w_dis_fire = dis_valid && dis_ready && !flush;
   assign w_wpos     = r_count - CW'(w_fire);

   always_comb begin
      w_src = 0;
      for (int i = 0; i < DEPTH; i++) begin
         w_src = (w_fire && (i >= int'(w_sel))) ? i + 1 : i;
         w_nvalid[i] = 1'b0;
         w_nb1[i]    = 1'b0;
         w_nb2[i]    = 1'b0;
         w_nuop[i]   = r_uop[i];
         if (w_src < DEPTH) begin
            w_nvalid[i] = r_valid[w_src];
            w_nb1[i]    = w_b1_upd[w_src];
            w_nb2[i]    = w_b2_upd[w_src];
            w_nuop[i]   = r_uop[w_src];
         end
         if (w_dis_fire && (i == int'(w_wpos))) begin
            w_nvalid[i] = 1'b1;
            w_nb1[i]    = w_dis_b1;
            w_nb2[i]    = w_dis_b2;
            w_nuop[i]   = dis_uop;
         end
      end
   end

   always_comb begin
      w_ncount = r_count;
      case ({w_dis_fire, w_fire})
         2'b10:   w_ncount = r_count + CW'(1);
         2'b01:   w_ncount = r_count - CW'(1);
         default: w_ncount = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_b1    <= '0;
         r_b2    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_uop[i] <= '0;
      end else if (flush) begin
         r_valid <= '0;
         r_count <= '0;
      end else begin
         r_valid <= w_nvalid;
         r_b1    <= w_nb1;
         r_b2    <= w_nb2;
         r_count <= w_ncount;
         for (int i = 0; i < DEPTH; i++) r_uop[i] <= w_nuop[i];
      end
   end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: age order, wakeup timing, full/flush/reset.
module tb_int_issue_queue;
   import int_issue_queue_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          dis_valid;
   logic          dis_ready;
   iq_uop_t       dis_uop;
   logic          dis_prs1_busy;
   logic          dis_prs2_busy;
   logic [1:0]    wake_valid;
   logic [11:0]   wake_pdst;
   logic          iss_valid;
   logic          iss_ready;
   iq_uop_t       iss_uop;
   logic [3:0]    count;

   int total = 0;
   int bad   = 0;

   int_issue_queue dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .dis_valid     (dis_valid),
      .dis_ready     (dis_ready),
      .dis_uop       (dis_uop),
      .dis_prs1_busy (dis_prs1_busy),
      .dis_prs2_busy (dis_prs2_busy),
      .wake_valid    (wake_valid),
      .wake_pdst     (wake_pdst),
      .iss_valid     (iss_valid),
      .iss_ready     (iss_ready),
      .iss_uop       (iss_uop),
      .count         (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic iq_uop_t mk(input uopc::micro_opcode_t op, input logic [4:0] rob,
                                  input logic [5:0] p1, input logic [5:0] p2,
                                  input logic u1, input logic u2);
      iq_uop_t u;
      u.uopcode    = op;
      u.packed_imm = {15'h0, rob} ^ 20'h00A50;
      u.imm_type   = immt::IMM_I;
      u.prs1       = p1;
      u.prs2       = p2;
      u.pdst       = {1'b1, rob};
      u.rob_idx    = rob;
      u.uses_rs1   = u1;
      u.uses_rs2   = u2;
      return u;
   endfunction

   task automatic disp(input iq_uop_t u, input logic b1, input logic b2);
      dis_valid     = 1'b1;
      dis_uop       = u;
      dis_prs1_busy = b1;
      dis_prs2_busy = b2;
      tick();
      dis_valid     = 1'b0;
      dis_prs1_busy = 1'b0;
      dis_prs2_busy = 1'b0;
   endtask

   initial begin
      iq_uop_t u;
      rst_n = 1'b0; flush = 1'b0; dis_valid = 1'b0; dis_uop = '0;
      dis_prs1_busy = 1'b0; dis_prs2_busy = 1'b0;
      wake_valid = '0; wake_pdst = '0; iss_ready = 1'b0;
      #2;
      chk("rst_count", count, 0);
      chk("rst_iss_valid", iss_valid, 0);
      chk("rst_dis_ready", dis_ready, 1);
      chk("rst_iss_uop", iss_uop, 0);
      #5 rst_n = 1'b1;
      tick();

      // single ready addi: visible next cycle, then drained
      u = mk(uopc::UOP_ADDI, 5'd1, 6'd5, 6'd0, 1'b1, 1'b0);
      iss_ready = 1'b1;
      dis_valid = 1'b1; dis_uop = u;
      #1 chk("t1_no_bypass", iss_valid, 0);
      tick();
      dis_valid = 1'b0;
      #1;
      chk("t1_iss_valid", iss_valid, 1);
      chk("t1_iss_uop", iss_uop, u);
      chk("t1_count1", count, 1);
      tick();
      chk("t1_count0", count, 0);
      chk("t1_empty", iss_valid, 0);

      // younger ready uop bypasses older busy one; wakeup takes effect a cycle later
      iss_ready = 1'b0;
      disp(mk(uopc::UOP_ADD, 5'd2, 6'd7, 6'd0, 1'b1, 1'b0), 1'b1, 1'b0);
      disp(mk(uopc::UOP_SUB, 5'd3, 6'd4, 6'd0, 1'b1, 1'b0), 1'b0, 1'b0);
      chk("t2_count", count, 2);
      chk("t2_b_first", iss_uop.rob_idx, 3);
      iss_ready = 1'b1;
      tick();
      chk("t2_count_after_b", count, 1);
      chk("t2_a_blocked", iss_valid, 0);
      wake_valid = 2'b01; wake_pdst = {6'd0, 6'd7};
      #1 chk("t2_wake_not_same_cycle", iss_valid, 0);
      tick();
      wake_valid = '0;
      #1;
      chk("t2_a_valid", iss_valid, 1);
      chk("t2_a_rob", iss_uop.rob_idx, 2);
      tick();
      chk("t2_count0", count, 0);

      // wakeup coincident with dispatch clears the incoming busy bit
      iss_ready = 1'b0;
      wake_valid = 2'b10; wake_pdst = {6'd9, 6'd63};
      disp(mk(uopc::UOP_BEQ, 5'd4, 6'd0, 6'd9, 1'b1, 1'b1), 1'b0, 1'b1);
      wake_valid = '0;
      #1;
      chk("t3_valid", iss_valid, 1);
      chk("t3_rob", iss_uop.rob_idx, 4);
      iss_ready = 1'b1;
      tick();
      chk("t3_count0", count, 0);

      // fill to DEPTH, full refuses even while issuing, drain in age order
      iss_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         disp(mk(uopc::UOP_ADD, 5'(i), 6'(i + 1), 6'd0, 1'b1, 1'b0), 1'b0, 1'b0);
      chk("t4_full_count", count, 8);
      chk("t4_full_ready", dis_ready, 0);
      iss_ready = 1'b1;
      dis_valid = 1'b1; dis_uop = mk(uopc::UOP_OR, 5'd20, 6'd1, 6'd0, 1'b1, 1'b0);
      #1 chk("t4_rob0", iss_uop.rob_idx, 0);
      tick();
      dis_valid = 1'b0;
      chk("t4_ready_after_issue", dis_ready, 1);
      chk("t4_count7", count, 7);
      for (int k = 1; k < 8; k++) begin
         chk("t4_drain_order", iss_uop.rob_idx, 64'(k));
         tick();
      end
      chk("t4_refused_dropped", count, 0);

      // issue from the middle while dispatching: collapse and append at count-1
      iss_ready = 1'b0;
      disp(mk(uopc::UOP_ADD, 5'd10, 6'd11, 6'd0, 1'b1, 1'b0), 1'b1, 1'b0);
      disp(mk(uopc::UOP_ADD, 5'd11, 6'd1, 6'd0, 1'b1, 1'b0), 1'b0, 1'b0);
      disp(mk(uopc::UOP_ADD, 5'd12, 6'd13, 6'd0, 1'b1, 1'b0), 1'b1, 1'b0);
      disp(mk(uopc::UOP_ADD, 5'd13, 6'd0, 6'd14, 1'b1, 1'b1), 1'b0, 1'b1);
      iss_ready = 1'b1;
      dis_valid = 1'b1; dis_uop = mk(uopc::UOP_XOR, 5'd14, 6'd15, 6'd0, 1'b1, 1'b0);
      dis_prs1_busy = 1'b1;
      #1 chk("t5_mid_rob", iss_uop.rob_idx, 11);
      tick();
      dis_valid = 1'b0; dis_prs1_busy = 1'b0;
      chk("t5_count_stays", count, 4);
      chk("t5_none_ready", iss_valid, 0);
      wake_valid = 2'b11; wake_pdst = {6'd13, 6'd11};
      tick();
      wake_valid = '0;
      #1 chk("t5_oldest_rob10", iss_uop.rob_idx, 10);
      tick();
      chk("t5_next_rob12", iss_uop.rob_idx, 12);
      tick();
      wake_valid = 2'b11; wake_pdst = {6'd15, 6'd14};
      #1 chk("t5_wait", iss_valid, 0);
      tick();
      wake_valid = '0;
      #1 chk("t5_rob13_before_14", iss_uop.rob_idx, 13);
      tick();
      chk("t5_rob14_last", iss_uop.rob_idx, 14);
      tick();
      chk("t5_count0", count, 0);

      // flush with coincident dispatch
      iss_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         disp(mk(uopc::UOP_AND, 5'(i + 20), 6'd2, 6'd0, 1'b1, 1'b0), 1'b0, 1'b0);
      chk("t6_count5", count, 5);
      iss_ready = 1'b1; flush = 1'b1;
      dis_valid = 1'b1; dis_uop = mk(uopc::UOP_LUI, 5'd30, 6'd0, 6'd0, 1'b0, 1'b0);
      #1 chk("t6_flush_iss_valid", iss_valid, 0);
      tick();
      flush = 1'b0; dis_valid = 1'b0;
      #1;
      chk("t6_count0", count, 0);
      chk("t6_dropped_not_issued", iss_valid, 0);

      // asynchronous reset between edges
      iss_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         disp(mk(uopc::UOP_SLT, 5'(i + 5), 6'd3, 6'd0, 1'b1, 1'b0), 1'b0, 1'b0);
      chk("t7_count3", count, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_async_count", count, 0);
      chk("t7_async_iss_valid", iss_valid, 0);
      chk("t7_async_dis_ready", dis_ready, 1);
      #1 rst_n = 1'b1;
      tick();
      chk("t7_post_count", count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Collapsing, age-ordered issue queue for integer uops (ALU and branch).
- Sits between dispatch/rename and the register-read stage. That stage decodes each issued uop into ALU/branch controls and expands its packed immediate.
- Holds uops until both physical sources are ready, using writeback wakeup broadcasts to track readiness.
- Issues at most one uop per cycle, always the oldest ready one.

Parameters:
- DEPTH, 8, number of queue entries (power of two not required, minimum 2).
- PREG_W, 6, physical register index width.
- ROB_W, 5, reorder-buffer index width.
- NWAKE, 2, number of wakeup broadcast ports per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; discards all entries.
- dis_valid  in  1  dispatch offers a uop.
- dis_ready  out  1  queue accepts a dispatch this cycle.
- dis_uop  in  iq_uop_t  uop fields: uopcode, packed_imm[19:0], imm_type, prs1, prs2, pdst, rob_idx, uses_rs1, uses_rs2.
- dis_prs1_busy  in  1  prs1 not yet written at dispatch time.
- dis_prs2_busy  in  1  prs2 not yet written at dispatch time.
- wake_valid  in  NWAKE  per-port wakeup strobe.
- wake_pdst  in  NWAKE*PREG_W  per-port woken physical register.
- iss_valid  out  1  a ready uop is presented to register-read.
- iss_ready  in  1  register-read accepts the presented uop this cycle.
- iss_uop  out  iq_uop_t  selected uop.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async, rst_n=0): all entry valid bits 0, count=0, iss_valid=0, dis_ready=1, iss_uop=0.
- Storage: entry i holds valid, uop, b1, b2 (busy bits). Entry 0 is oldest; valid entries are always contiguous from index 0.
- Busy bits:
  - A source with uses_rsN=0, or prsN=0, is never busy.
  - Busy is cleared when any wake_valid[k]=1 and wake_pdst[k] equals that source.
- Dispatch-time wakeup: a wakeup in the same cycle as dispatch also clears the incoming dis_prsN_busy bit, so no wakeup is lost.
- Select:
  - Combinational.
  - Picks the lowest index i with valid, !b1 and !b2, evaluated on the registered busy bits.
  - A wakeup in cycle t therefore makes an entry eligible in cycle t+1 at the earliest.
  - iss_valid = any ready entry && !flush.
  - iss_uop = selected entry, or 0 when iss_valid=0.
- Handshake:
  - Issue fires when iss_valid && iss_ready.
  - This is select-and-grant, not a sticky handshake: with iss_ready=0 the presented uop may change next cycle if an older entry becomes ready.
  - Nothing is removed unless issue fires.
- Update on the clock edge:
  1. Removal: on issue from index s, entries s+1..count-1 shift down by one and carry their wakeup-updated busy bits.
  2. Dispatch: written to index count-1 if an issue fired this cycle, else to index count.
- dis_ready = (count < DEPTH), registered-state only. A full queue refuses dispatch even while issuing, so there is no combinational path from iss_ready to dis_ready.
- count: +1 on dispatch, -1 on issue, unchanged on both or neither. Never exceeds DEPTH, never underflows.
- Flush:
  - Next edge clears all valid bits and sets count=0.
  - Same-cycle dispatch is dropped; iss_valid is forced 0 during the flush cycle.
  - Flush has priority over all other events.
- Reset mid-operation: immediate clear regardless of clock.
- No latency beyond one cycle from dispatch to earliest issue. A uop dispatched ready in cycle t can issue in t+1.

Decomposition:
- Shared ctrl_sigs package:
  - iq_uop_t packed struct, using uopc::micro_opcode_t and immt::imm_type_t.
  - IQ_DEPTH default.
  - A wakeup struct {valid, pdst}.
- One sub-module, iq_entry_wake: per-entry busy-bit update against all NWAKE ports. It is reused for the incoming dispatch uop.
- Select is a priority encoder inline in the top module.

Test Plan:
- Reset, then dispatch addi with prs1=5 not busy -> iss_valid=1 the next cycle with that uop; with iss_ready=1, count goes 1->0.
- Dispatch A (prs1=7 busy), then B (ready) -> B issues first. Wake pdst=7 at cycle t -> A issues at t+1.
- Dispatch with dis_prs2_busy=1 on prs2=9 while wake_valid[1]=1, wake_pdst[1]=9 in the same cycle -> entry issues the next cycle.
- Fill 8 ready entries with iss_ready=0 -> dis_ready=0 and count=8. Raise iss_ready -> rob_idx order 0..7 on consecutive cycles; dis_ready=1 after the first issue.
- Occupancy 4, entry 1 ready, simultaneous dispatch -> entry 1 issues; old entries 2,3 move to 1,2; new uop lands at index 3; count stays 4.
- Occupancy 5, assert flush together with dis_valid -> iss_valid=0 that cycle, count=0 next cycle, dropped uop never issues.
- Assert rst_n=0 mid-stream between edges -> count=0 and iss_valid=0 immediately.
